fp_add_scheduler: RTL and testbench

Sequencer and two-way arbiter that shares one floating-point adder datapath (8-bit mantissa, 3-bit exponent, sign) between two requesters. It accepts operand pairs over valid/ready handshakes, selects a winner by round-robin, and holds the operands stable on the adder inputs for a programmable settle time. It then captures the adder result and returns it on a single response channel tagged with the requester ID. It sits between the issuing logic and the adder instance and does no arithmetic itself.

---
 rtl/fp_add_scheduler_if.sv | 27 ++
 rtl/fp_add_scheduler.sv | 85 ++++++++
 tb/tb_fp_add_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fp_add_scheduler_if.sv
// Request, adder and response signals shared between the issuing logic and the scheduler.
interface fp_add_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [23:0] req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [23:0] req1_op;
    logic [23:0] add_op;
    logic [11:0] add_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [11:0] rsp_data;
    logic        busy;
    logic [7:0]  done_cnt;

    modport slave (
        input  req0_valid, req0_op, req1_valid, req1_op, add_res, rsp_ready,
        output req0_ready, req1_ready, add_op, rsp_valid, rsp_id, rsp_data, busy, done_cnt
    );

    modport master (
        output req0_valid, req0_op, req1_valid, req1_op, add_res, rsp_ready,
        input  req0_ready, req1_ready, add_op, rsp_valid, rsp_id, rsp_data, busy, done_cnt
    );
endinterface

// File: rtl/fp_add_scheduler.sv
// Round-robin sequencer sharing one FP adder between two requesters; holds operands
// for ADD_LAT cycles, captures the result and returns it tagged with the requester id.
module fp_add_scheduler #(
    parameter int unsigned ADD_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    fp_add_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT = 4'(ADD_LAT);

    state_t      state;
    logic [23:0] op_reg;
    logic        id_reg;
    logic        last_grant;
    logic [3:0]  cnt;
    logic [11:0] rsp_data_r;
    logic        rsp_valid_r;
    logic        busy_r;
    logic [7:0]  done_cnt_r;
    logic        grant1;
    logic        accept;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
        accept = (state == IDLE) & ~rst & (bus.req0_valid | bus.req1_valid);
    end

    assign bus.req0_ready = accept & ~grant1;
    assign bus.req1_ready = accept & grant1;
    assign bus.add_op     = op_reg;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = id_reg;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.busy       = busy_r;
    assign bus.done_cnt   = done_cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_reg      <= '0;
            id_reg      <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            rsp_data_r  <= '0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_cnt_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_reg     <= grant1 ? bus.req1_op : bus.req0_op;
                        id_reg     <= grant1;
                        last_grant <= grant1;
                        cnt        <= LAT;
                        busy_r     <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Result is sampled in the last of the ADD_LAT hold cycles.
                    if (cnt == 4'd1) begin
                        rsp_data_r  <= bus.add_res;
                        rsp_valid_r <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        done_cnt_r  <= done_cnt_r + 8'd1;
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed/randomized bench for fp_add_scheduler against a transaction-level model.
module tb_fp_add_scheduler;
    localparam int unsigned LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   m_last;
    int   m_done;

    always #5 clk = ~clk;

    fp_add_scheduler_if bus ();
    fp_add_scheduler_if bus1 ();

    fp_add_scheduler #(.ADD_LAT(LAT)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    fp_add_scheduler #(.ADD_LAT(1))   u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req_inputs();
        bus.req0_valid = 1'($urandom);
        bus.req1_valid = 1'($urandom);
        bus.req0_op    = 24'($urandom);
        bus.req1_op    = 24'($urandom);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_add_op"},    32'(bus.add_op),    32'h0);
        chk({tag, "_rsp_data"},  32'(bus.rsp_data),  32'h0);
        chk({tag, "_rsp_id"},    32'(bus.rsp_id),    32'h0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        chk({tag, "_busy"},      32'(bus.busy),      32'h0);
        chk({tag, "_done_cnt"},  32'(bus.done_cnt),  32'h0);
    endtask

    // One complete transaction; entered and left just after a rising edge with DUT idle.
    task automatic txn(input bit v0_in, input bit v1_in, input int stall, input bit capt);
        logic [23:0] op0, op1, exp_op;
        logic [11:0] r;
        bit          v0, v1, g;
        v0  = v0_in | ~v1_in;
        v1  = v1_in;
        op0 = 24'($urandom);
        op1 = 24'($urandom);
        r   = '0;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_op    = op0;
        bus.req1_op    = op1;
        bus.add_res    = 12'($urandom);
        bus.rsp_ready  = 1'($urandom);
        #1;
        chk("idle_busy",      32'(bus.busy),      32'h0);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("done_cnt",       32'(bus.done_cnt),  32'(m_done % 256));
        g = (v0 && v1) ? !m_last : v1;
        chk("req0_ready", 32'(bus.req0_ready), 32'(v0 && !g));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g));
        exp_op = g ? op1 : op0;
        m_last = g;
        next_cycle();
        for (int unsigned k = 1; k <= LAT; k++) begin
            rand_req_inputs();
            r = capt ? ((k == LAT) ? 12'h777 : 12'h111) : 12'($urandom);
            bus.add_res   = r;
            bus.rsp_ready = 1'($urandom);
            #1;
            chk("wait_busy",      32'(bus.busy),       32'h1);
            chk("wait_rsp_valid", 32'(bus.rsp_valid),  32'h0);
            chk("wait_add_op",    32'(bus.add_op),     32'(exp_op));
            chk("wait_req0_rdy",  32'(bus.req0_ready), 32'h0);
            chk("wait_req1_rdy",  32'(bus.req1_ready), 32'h0);
            next_cycle();
        end
        for (int s = 0; s <= stall; s++) begin
            rand_req_inputs();
            bus.add_res   = 12'($urandom);
            bus.rsp_ready = (s == stall);
            #1;
            chk("rsp_valid",     32'(bus.rsp_valid),  32'h1);
            chk("rsp_data",      32'(bus.rsp_data),   32'(r));
            chk("rsp_id",        32'(bus.rsp_id),     32'(g));
            chk("rsp_busy",      32'(bus.busy),       32'h1);
            chk("rsp_add_op",    32'(bus.add_op),     32'(exp_op));
            chk("rsp_req0_rdy",  32'(bus.req0_ready), 32'h0);
            chk("rsp_req1_rdy",  32'(bus.req1_ready), 32'h0);
            next_cycle();
        end
        m_done++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_op = '0; bus.req1_op = '0;
        bus.add_res = '0; bus.rsp_ready = 0;
        bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.req0_op = '0; bus1.req1_op = '0;
        bus1.add_res = '0; bus1.rsp_ready = 0;
        m_last = 1'b1;
        m_done = 0;

        // Reset state, with requests pending while rst is high.
        next_cycle();
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        chk_reset_vals("rst");
        chk("rst_req0_rdy", 32'(bus.req0_ready), 32'h0);
        chk("rst_req1_rdy", 32'(bus.req1_ready), 32'h0);
        rst = 1'b0;
        bus.req0_valid = 0; bus.req1_valid = 0;
        next_cycle();

        // Single operation on the ADD_LAT=1 instance.
        bus1.req0_valid = 1; bus1.req0_op = 24'h1234AB; bus1.add_res = 12'hA5C;
        #1;
        chk("s1_req0_rdy", 32'(bus1.req0_ready), 32'h1);
        chk("s1_req1_rdy", 32'(bus1.req1_ready), 32'h0);
        next_cycle();
        bus1.req0_valid = 0; bus1.req0_op = 24'h0;
        #1;
        chk("s1_add_op", 32'(bus1.add_op),    32'h1234AB);
        chk("s1_wait",   32'(bus1.rsp_valid), 32'h0);
        chk("s1_busy",   32'(bus1.busy),      32'h1);
        next_cycle();
        chk("s1_rsp_valid", 32'(bus1.rsp_valid), 32'h1);
        chk("s1_rsp_id",    32'(bus1.rsp_id),    32'h0);
        chk("s1_rsp_data",  32'(bus1.rsp_data),  32'hA5C);
        bus1.rsp_ready = 1;
        next_cycle();
        bus1.rsp_ready = 0;
        #1;
        chk("s1_done_cnt", 32'(bus1.done_cnt), 32'h1);
        chk("s1_idle",     32'(bus1.busy),     32'h0);

        // Ties, back-pressure, capture point, then randomized traffic.
        for (int i = 0; i < 4; i++) txn(1'b1, 1'b1, 0, 1'b0);
        txn(1'b1, 1'b0, 10, 1'b0);
        txn(1'b0, 1'b1, 10, 1'b0);
        txn(1'b1, 1'b1, 0, 1'b1);
        for (int i = 0; i < 20; i++)
            txn(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);

        // Reset during WAIT discards the operation.
        bus.req0_valid = 1; bus.req1_valid = 1;
        bus.req0_op = 24'($urandom); bus.req1_op = 24'($urandom);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("mid_rst_req0_rdy", 32'(bus.req0_ready), 32'h0);
        chk("mid_rst_req1_rdy", 32'(bus.req1_ready), 32'h0);
        next_cycle();
        rst = 1'b0;
        bus.req0_valid = 0; bus.req1_valid = 0;
        #1;
        chk_reset_vals("mid_rst");
        m_last = 1'b1;
        m_done = 0;
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            next_cycle();
            chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        txn(1'b1, 1'b1, 0, 1'b0);

        // Completion counter wrap.
        for (int i = 0; i < 255; i++)
            txn(1'($urandom), 1'($urandom), 0, 1'b0);
        #1;
        chk("wrap_zero", 32'(bus.done_cnt), 32'(m_done % 256));
        txn(1'($urandom), 1'($urandom), 0, 1'b0);
        bus.req0_valid = 0; bus.req1_valid = 0;
        #1;
        chk("wrap_one", 32'(bus.done_cnt), 32'(m_done % 256));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
